wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Sequences the single register-file write port that feeds the 8×16 register-file write stage (ports vsel, write, writenum, C, mdata).
- Two requesters compete for the port:
  - ALU result path (drives C).
  - Memory load path (drives mdata).
- Arbitrates with fixed memory priority plus an anti-starvation counter for the ALU.
- Registers the winning request, so write, vsel, writenum and the data lanes present one clean write per clock.

Parameters:
- WIDTH, 16, data width of both requester data lanes and of wb_c / wb_mdata.
- MAX_WAIT, 3, consecutive cycles the ALU may be refused while requesting before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- alu_req  input  1  ALU has a result to write back; held with its data until accepted.
- alu_dest  input  3  ALU destination register number.
- alu_data  input  WIDTH  ALU result.
- alu_ack  output  1  combinational; high when the ALU request is accepted this cycle.
- mem_req  input  1  memory load data valid; held until accepted.
- mem_dest  input  3  load destination register number.
- mem_data  input  WIDTH  load data.
- mem_ack  output  1  combinational; high when the memory request is accepted this cycle.
- wb_write  output  1  registered; to register-file write.
- wb_vsel  output  1  registered; 1 = write mdata, 0 = write C.
- wb_writenum  output  3  registered; destination register number.
- wb_c  output  WIDTH  registered; to register-file C.
- wb_mdata  output  WIDTH  registered; to register-file mdata.
- alu_starved  output  1  registered; high when the wait counter has reached MAX_WAIT.

Behaviour:
- Reset (async, reset_n=0), all registered outputs cleared:
  - wb_write=0, wb_vsel=0, wb_writenum=0, wb_c=0, wb_mdata=0.
  - wait_cnt=0, alu_starved=0.
- While reset_n=0, alu_ack and mem_ack are 0.
- Reset mid-operation drops any write not yet presented; requesters keep req high and are re-accepted after reset releases.
- Arbitration, evaluated every cycle:
  - Exactly one request is accepted per cycle; the two acks are never high together.
  - Only mem_req: mem_ack=1.
  - Only alu_req: alu_ack=1.
  - Both requesting, alu_starved=0: memory wins.
  - Both requesting, alu_starved=1: ALU wins.
  - Neither requesting: both acks 0.
- Latency: one cycle.
  - A request accepted in cycle N appears on wb_* in cycle N+1, with wb_write=1 for exactly that cycle.
  - With no acceptance in cycle N, wb_write=0 in cycle N+1; wb_writenum, wb_c, wb_mdata hold their previous values.
- Memory accept: wb_vsel=1, wb_writenum=mem_dest, wb_mdata=mem_data; wb_c holds.
- ALU accept: wb_vsel=0, wb_writenum=alu_dest, wb_c=alu_data; wb_mdata holds.
- Full throughput: back-to-back accepts give wb_write=1 on consecutive cycles; no bubbles inserted.
- Starvation counter wait_cnt (4 bits):
  - Increments when alu_req=1 and alu_ack=0, saturating at MAX_WAIT.
  - Clears when alu_ack=1 or alu_req=0.
  - alu_starved = (wait_cnt == MAX_WAIT), registered.
- Same destination from both requesters in one cycle: no merging. The winner is written first; the loser is written on a later cycle. Register order therefore matches grant order.
- Back-to-back same destination is allowed; each accepted request produces its own write.
- No X on outputs after reset; the acks are pure functions of the reqs and alu_starved.

Test Plan:
1. Reset then idle: reset_n low mid-write (wb_write=1) -> all wb_* outputs 0 immediately; both acks 0; with no requests, wb_write stays 0.
2. ALU only: alu_req=1, alu_dest=3, alu_data=16'h00A5 in cycle 0 -> alu_ack=1 in cycle 0; cycle 1 shows wb_write=1, wb_vsel=0, wb_writenum=3, wb_c=16'h00A5; cycle 2 wb_write=0.
3. Memory only: mem_req=1, mem_dest=7, mem_data=16'hBEEF -> mem_ack=1; next cycle wb_write=1, wb_vsel=1, wb_writenum=7, wb_mdata=16'hBEEF; wb_c unchanged.
4. Contention: both held high for 8 cycles, MAX_WAIT=3 -> grant order MEM, MEM, MEM, ALU, MEM, MEM, MEM, ALU; alu_starved high in cycles 3 and 7 only; wb_write=1 every cycle from cycle 1.
5. Same destination: alu_dest=mem_dest=2 in the same cycle, alu_data=1, mem_data=2 -> first write vsel=1 with data 2, next write vsel=0 with data 1; both on writenum=2.
6. Counter clear: alu_req high but refused 2 cycles, then dropped 1 cycle, then raised with mem_req still high -> wait_cnt restarts from 0; ALU is forced only after a further 3 refusals.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: memory loads win by default, and the ALU is
// forced through after MAX_WAIT consecutive refusals. The winner is registered onto wb_*.
module wb_port_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alu_req,
  input  logic [2:0]       alu_dest,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ack,
  input  logic             mem_req,
  input  logic [2:0]       mem_dest,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_ack,
  output logic             wb_write,
  output logic             wb_vsel,
  output logic [2:0]       wb_writenum,
  output logic [WIDTH-1:0] wb_c,
  output logic [WIDTH-1:0] wb_mdata,
  output logic             alu_starved
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt, wait_nxt;

  // Acks are forced low while reset is asserted so nothing is granted into a cleared pipe.
  always_comb begin
    alu_ack = reset_n & alu_req & (~mem_req | alu_starved);
    mem_ack = reset_n & mem_req & ~(alu_req & alu_starved);
  end

  always_comb begin
    wait_nxt = '0;
    if (alu_req && !alu_ack)
      wait_nxt = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 4'd1;
  end

  // alu_starved is registered from the next count so it lines up with wait_cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      alu_starved <= 1'b0;
    end else begin
      wait_cnt    <= wait_nxt;
      alu_starved <= (wait_nxt == MAX_CNT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_write    <= 1'b0;
      wb_vsel     <= 1'b0;
      wb_writenum <= '0;
      wb_c        <= '0;
      wb_mdata    <= '0;
    end else begin
      wb_write <= alu_ack | mem_ack;
      if (mem_ack) begin
        wb_vsel     <= 1'b1;
        wb_writenum <= mem_dest;
        wb_mdata    <= mem_data;
      end else if (alu_ack) begin
        wb_vsel     <= 1'b0;
        wb_writenum <= alu_dest;
        wb_c        <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, single requesters, contention,
// same-destination ordering and starvation-counter clearing.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_req, mem_req;
  logic [2:0]  alu_dest, mem_dest;
  logic [15:0] alu_data, mem_data;
  logic        alu_ack, mem_ack;
  logic        wb_write, wb_vsel, alu_starved;
  logic [2:0]  wb_writenum;
  logic [15:0] wb_c, wb_mdata;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.WIDTH(16), .MAX_WAIT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_req(alu_req), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ack(mem_ack),
    .wb_write(wb_write), .wb_vsel(wb_vsel), .wb_writenum(wb_writenum),
    .wb_c(wb_c), .wb_mdata(wb_mdata), .alu_starved(alu_starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_alu [8];
  logic t6_req  [7];
  logic t6_ack  [7];

  initial begin
    reset_n = 1'b0; alu_req = 1'b0; mem_req = 1'b0;
    alu_dest = '0; mem_dest = '0; alu_data = '0; mem_data = '0;
    step(); step();

    // reset state, acks held low during reset
    chk("rst_write",   32'(wb_write), 0);
    chk("rst_vsel",    32'(wb_vsel), 0);
    chk("rst_num",     32'(wb_writenum), 0);
    chk("rst_c",       32'(wb_c), 0);
    chk("rst_mdata",   32'(wb_mdata), 0);
    chk("rst_starved", 32'(alu_starved), 0);
    alu_req = 1'b1; mem_req = 1'b1; #1;
    chk("rst_alu_ack", 32'(alu_ack), 0);
    chk("rst_mem_ack", 32'(mem_ack), 0);
    alu_req = 1'b0; mem_req = 1'b0;
    reset_n = 1'b1;
    step();
    chk("idle_write0", 32'(wb_write), 0);
    step();
    chk("idle_write1", 32'(wb_write), 0);

    // ALU only
    alu_req = 1'b1; alu_dest = 3'd3; alu_data = 16'h00A5; #1;
    chk("alu_only_ack", 32'(alu_ack), 1);
    chk("alu_only_mack", 32'(mem_ack), 0);
    step();
    alu_req = 1'b0;
    chk("alu_wr",    32'(wb_write), 1);
    chk("alu_vsel",  32'(wb_vsel), 0);
    chk("alu_num",   32'(wb_writenum), 3);
    chk("alu_c",     32'(wb_c), 'h00A5);
    chk("alu_mdata", 32'(wb_mdata), 0);
    step();
    chk("alu_wr_off", 32'(wb_write), 0);
    chk("alu_num_hold", 32'(wb_writenum), 3);

    // memory only
    mem_req = 1'b1; mem_dest = 3'd7; mem_data = 16'hBEEF; #1;
    chk("mem_only_ack", 32'(mem_ack), 1);
    chk("mem_only_aack", 32'(alu_ack), 0);
    step();
    mem_req = 1'b0;
    chk("mem_wr",    32'(wb_write), 1);
    chk("mem_vsel",  32'(wb_vsel), 1);
    chk("mem_num",   32'(wb_writenum), 7);
    chk("mem_mdata", 32'(wb_mdata), 'hBEEF);
    chk("mem_c_hold", 32'(wb_c), 'h00A5);

    // reset while a write is being presented
    reset_n = 1'b0; mem_req = 1'b1; mem_dest = 3'd5; mem_data = 16'h1234; #1;
    chk("midrst_write", 32'(wb_write), 0);
    chk("midrst_vsel",  32'(wb_vsel), 0);
    chk("midrst_num",   32'(wb_writenum), 0);
    chk("midrst_c",     32'(wb_c), 0);
    chk("midrst_mdata", 32'(wb_mdata), 0);
    chk("midrst_mack",  32'(mem_ack), 0);
    reset_n = 1'b1; #1;
    chk("postrst_mack", 32'(mem_ack), 1);
    step();
    mem_req = 1'b0;
    chk("postrst_wr",    32'(wb_write), 1);
    chk("postrst_num",   32'(wb_writenum), 5);
    chk("postrst_mdata", 32'(wb_mdata), 'h1234);
    step();

    // contention: MEM x3, ALU, MEM x3, ALU
    exp_alu = '{0, 0, 0, 1, 0, 0, 0, 1};
    alu_req = 1'b1; alu_dest = 3'd1; alu_data = 16'h1111;
    mem_req = 1'b1; mem_dest = 3'd6; mem_data = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("cont_aack%0d", i), 32'(alu_ack), 32'(exp_alu[i]));
      chk($sformatf("cont_mack%0d", i), 32'(mem_ack), 32'(!exp_alu[i]));
      chk($sformatf("cont_starv%0d", i), 32'(alu_starved), 32'(exp_alu[i]));
      step();
      chk($sformatf("cont_wr%0d", i), 32'(wb_write), 1);
      chk($sformatf("cont_vsel%0d", i), 32'(wb_vsel), 32'(!exp_alu[i]));
    end
    alu_req = 1'b0; mem_req = 1'b0;
    step();
    chk("cont_drain", 32'(wb_write), 0);

    // same destination: memory first, then ALU
    alu_req = 1'b1; alu_dest = 3'd2; alu_data = 16'd1;
    mem_req = 1'b1; mem_dest = 3'd2; mem_data = 16'd2; #1;
    chk("same_mack", 32'(mem_ack), 1);
    step();
    mem_req = 1'b0;
    chk("same1_wr",    32'(wb_write), 1);
    chk("same1_vsel",  32'(wb_vsel), 1);
    chk("same1_num",   32'(wb_writenum), 2);
    chk("same1_mdata", 32'(wb_mdata), 2);
    #1;
    chk("same_aack", 32'(alu_ack), 1);
    step();
    alu_req = 1'b0;
    chk("same2_wr",   32'(wb_write), 1);
    chk("same2_vsel", 32'(wb_vsel), 0);
    chk("same2_num",  32'(wb_writenum), 2);
    chk("same2_c",    32'(wb_c), 1);
    step();

    // counter clear when ALU drops its request
    t6_req = '{1, 1, 0, 1, 1, 1, 1};
    t6_ack = '{0, 0, 0, 0, 0, 0, 1};
    mem_req = 1'b1; alu_dest = 3'd4; alu_data = 16'h0C0C;
    for (int i = 0; i < 7; i++) begin
      alu_req = t6_req[i]; #1;
      chk($sformatf("clr_aack%0d", i), 32'(alu_ack), 32'(t6_ack[i]));
      chk($sformatf("clr_starv%0d", i), 32'(alu_starved), 32'(t6_ack[i]));
      step();
    end
    alu_req = 1'b0; mem_req = 1'b0;
    chk("clr_alu_wr", 32'(wb_vsel), 0);
    chk("clr_alu_c",  32'(wb_c), 'h0C0C);
    step(); step();
    chk("final_idle", 32'(wb_write), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
